// File: rtl/pipeline_adder_stages.sv
// Four-stage segmented ripple adder with stall (pause), flush and registered result.
// Optional macro PIPE_ADDER_OVF_EN adds a registered signed-overflow output (ovf).
module pipeline_adder_stages #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int S = WIDTH / 4;

  // Handshake: an operand set transfers on a rising edge when in_valid && in_ready
  // and flush is low; in_ready is simply ~pause, there is no output-side backpressure.
  assign in_ready = ~pause;

  logic [3:0] v_q;

  // Stage 0 holds segment 0 of the sum plus the three untouched upper operand segments.
  logic [S-1:0]   s0_q, s0_d;
  logic [3*S-1:0] a0_q, a0_d, b0_q, b0_d;
  logic           c0_q, c0_d;
  logic [2*S-1:0] s1_q, s1_d;
  logic [2*S-1:0] a1_q, a1_d, b1_q, b1_d;
  logic           c1_q, c1_d;
  logic [3*S-1:0] s2_q, s2_d;
  logic [S-1:0]   a2_q, a2_d, b2_q, b2_d;
  logic           c2_q, c2_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [S:0] add0, add1, add2, add3;

  always_comb begin
    add0 = {1'b0, a[S-1:0]} + {1'b0, b[S-1:0]} + {{S{1'b0}}, cin};
    add1 = {1'b0, a0_q[S-1:0]} + {1'b0, b0_q[S-1:0]} + {{S{1'b0}}, c0_q};
    add2 = {1'b0, a1_q[S-1:0]} + {1'b0, b1_q[S-1:0]} + {{S{1'b0}}, c1_q};
    add3 = {1'b0, a2_q} + {1'b0, b2_q} + {{S{1'b0}}, c2_q};

    s0_d   = add0[S-1:0];
    c0_d   = add0[S];
    a0_d   = a[WIDTH-1:S];
    b0_d   = b[WIDTH-1:S];

    s1_d   = {add1[S-1:0], s0_q};
    c1_d   = add1[S];
    a1_d   = a0_q[3*S-1:S];
    b1_d   = b0_q[3*S-1:S];

    s2_d   = {add2[S-1:0], s1_q};
    c2_d   = add2[S];
    a2_d   = a1_q[2*S-1:S];
    b2_d   = b1_q[2*S-1:S];

    sum_d  = {add3[S-1:0], s2_q};
    cout_d = add3[S];
  end

`ifdef PIPE_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf_d = (a2_q[S-1] == b2_q[S-1]) && (add3[S-1] != a2_q[S-1]);
  assign ovf   = ovf_q;
`endif

  // Data registers only load behind a valid token, so bubbles and flushes
  // leave sum/cout holding the last delivered result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q    <= '0;
      s0_q   <= '0; a0_q <= '0; b0_q <= '0; c0_q <= 1'b0;
      s1_q   <= '0; a1_q <= '0; b1_q <= '0; c1_q <= 1'b0;
      s2_q   <= '0; a2_q <= '0; b2_q <= '0; c2_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef PIPE_ADDER_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (flush) begin
      v_q <= '0;
    end else if (!pause) begin
      v_q <= {v_q[2:0], in_valid};
      if (in_valid) begin
        s0_q <= s0_d; a0_q <= a0_d; b0_q <= b0_d; c0_q <= c0_d;
      end
      if (v_q[0]) begin
        s1_q <= s1_d; a1_q <= a1_d; b1_q <= b1_d; c1_q <= c1_d;
      end
      if (v_q[1]) begin
        s2_q <= s2_d; a2_q <= a2_d; b2_q <= b2_d; c2_q <= c2_d;
      end
      if (v_q[2]) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
`ifdef PIPE_ADDER_OVF_EN
        ovf_q  <= ovf_d;
`endif
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = v_q[3];

endmodule

// File: tb/tb_pipeline_adder_stages.sv
// Directed + short random bench for pipeline_adder_stages with a result queue.
// Build with PIPE_ADDER_OVF_EN defined to also exercise the ovf output.
module tb_pipeline_adder_stages;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst, pause, flush, in_valid, cin;
  logic             in_ready, cout, out_valid;
  logic [WIDTH-1:0] a, b, sum;
`ifdef PIPE_ADDER_OVF_EN
  logic             ovf;
`endif

  logic [WIDTH:0] exp_q[$];
  int             checks = 0;
  int             failures = 0;
  logic           adv_q = 1'b0;

  always #5 clk = ~clk;

  pipeline_adder_stages #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .pause(pause), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .out_valid(out_valid)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Caller guarantees rst=1, pause=0, flush=0 so the operand is accepted at the next edge.
  task automatic drive(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc);
    a = ta;
    b = tb_v;
    cin = tc;
    in_valid = 1'b1;
    exp_q.push_back({1'b0, ta} + {1'b0, tb_v} + {{WIDTH{1'b0}}, tc});
  endtask

  // A new result exists only after an edge that advanced the pipeline.
  always @(posedge clk) adv_q <= rst && !pause && !flush;

  always @(negedge clk) begin
    if (adv_q && out_valid) begin
      if (exp_q.size() == 0)
        chk("unexpected_result", {63'b0, out_valid}, 64'd0);
      else
        chk("result", {31'b0, cout, sum}, {31'b0, exp_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; pause = 1'b0; flush = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_sum", {32'b0, sum}, 64'd0);
    chk("reset_cout", {63'b0, cout}, 64'd0);
    chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
    pause = 1'b1;
    #1;
    chk("reset_in_ready_paused", {63'b0, in_ready}, 64'd0);
    pause = 1'b0;
    rst = 1'b1;

    // Single operand: latency of four edges including the accepting edge.
    drive(32'h0000_00FF, 32'h0000_0001, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("lat_e2", {63'b0, out_valid}, 64'd0);
    tick();
    chk("lat_e3", {63'b0, out_valid}, 64'd0);
    tick();
    chk("lat_e4", {63'b0, out_valid}, 64'd1);
    chk("lat_sum", {32'b0, sum}, 64'h0000_0100);

    // Back-to-back operands, full carry ripple then carry-in.
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    tick();
    drive(32'h1234_5678, 32'h1111_1111, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("b2b_first_valid", {63'b0, out_valid}, 64'd1);
    chk("b2b_first", {31'b0, cout, sum}, {31'b0, 1'b1, 32'h0000_0000});
    tick();
    chk("b2b_second", {31'b0, cout, sum}, {31'b0, 1'b0, 32'h2345_678A});
    tick();
    chk("b2b_drained", {63'b0, out_valid}, 64'd0);

    // Random traffic with occasional stalls.
    for (int i = 0; i < 24; i++) begin
      pause = ($urandom_range(0, 3) == 0);
      if (!pause && $urandom_range(0, 2) != 0)
        drive($urandom, $urandom, 1'($urandom_range(0, 1)));
      else begin
        in_valid = pause ? 1'($urandom_range(0, 1)) : 1'b0;
        a = $urandom;
        b = $urandom;
      end
      tick();
    end
    pause = 1'b0;
    in_valid = 1'b0;
    repeat (6) tick();
    chk("random_drained", 64'(exp_q.size()), 64'd0);

    // Pause for three edges starting at edge 2; result lands at edge 7.
    drive(32'h0000_1000, 32'h0000_0234, 1'b1);
    tick();
    pause = 1'b1;
    in_valid = 1'b1;
    a = 32'hDEAD_BEEF;
    repeat (3) begin
      tick();
      chk("pause_out_valid", {63'b0, out_valid}, 64'd0);
      chk("pause_in_ready", {63'b0, in_ready}, 64'd0);
    end
    pause = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("pause_e5", {63'b0, out_valid}, 64'd0);
    tick();
    chk("pause_e6", {63'b0, out_valid}, 64'd0);
    tick();
    chk("pause_e7", {63'b0, out_valid}, 64'd1);
    chk("pause_e7_sum", {32'b0, sum}, 64'h0000_1235);
    pause = 1'b1;
    repeat (2) begin
      tick();
      chk("hold_out_valid", {63'b0, out_valid}, 64'd1);
      chk("hold_sum", {32'b0, sum}, 64'h0000_1235);
    end
    pause = 1'b0;
    tick();
    chk("hold_release", {63'b0, out_valid}, 64'd0);

    // Flush (with pause) while three operands are in flight.
    drive(32'h0000_0001, 32'h0000_0001, 1'b0);
    tick();
    drive(32'h0000_0002, 32'h0000_0002, 1'b0);
    tick();
    drive(32'h0000_0003, 32'h0000_0003, 1'b0);
    tick();
    exp_q.delete();
    flush = 1'b1;
    pause = 1'b1;
    a = 32'h5555_5555;
    tick();
    chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
    chk("flush_sum_stable", {32'b0, sum}, 64'h0000_1235);
    flush = 1'b0;
    pause = 1'b0;
    drive(32'hA000_0000, 32'h6000_0001, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (2) begin
      tick();
      chk("post_flush_idle", {63'b0, out_valid}, 64'd0);
      chk("post_flush_sum_stable", {32'b0, sum}, 64'h0000_1235);
    end
    tick();
    chk("post_flush_result", {63'b0, out_valid}, 64'd1);
    chk("post_flush_value", {31'b0, cout, sum}, {31'b0, 1'b1, 32'h0000_0002});

    // Reset for one edge with two operands in flight.
    drive(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
    tick();
    drive(32'h7777_7777, 32'h1111_1111, 1'b1);
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    tick();
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_sum", {32'b0, sum}, 64'd0);
    chk("midrst_cout", {63'b0, cout}, 64'd0);
    rst = 1'b1;
    repeat (6) begin
      tick();
      chk("midrst_no_result", {63'b0, out_valid}, 64'd0);
    end

`ifdef PIPE_ADDER_OVF_EN
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    tick();
    drive(32'h8000_0000, 32'h8000_0000, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("ovf_pos", {31'b0, ovf, cout, sum}, {31'b0, 1'b1, 1'b0, 32'h8000_0000});
    tick();
    chk("ovf_neg", {31'b0, ovf, cout, sum}, {31'b0, 1'b1, 1'b1, 32'h0000_0000});
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("ovf_none", {62'b0, ovf, cout}, {62'b0, 1'b0, 1'b1});
`endif

    repeat (2) tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
